// File: rtl/store_queue.sv
// ---------------------------------------------------------------------------
// store_queue : store data queue between dispatch/AGU and the data-memory port
//
// Holds up to SDQ_ENTRIES in-flight stores in program order. Dispatch
// allocates entries at the tail. The AGU fills in address and data by index.
// The ROB marks the oldest uncommitted stores as committed. Committed stores
// with a valid address drain oldest-first over a valid/ready memory request.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   alloc_valid/ready  allocate one entry at the tail; alloc_idx is its index
//   sdq_marker         tail pointer including wrap bit (for the load queue)
//   addr_wr_*          AGU address/data write to an allocated entry
//   commit_cnt         number of oldest uncommitted stores retired this cycle
//   flush              squash every uncommitted entry
//   mem_req_*          head store request to memory (valid/ready)
//   count, empty       occupancy derived from the registered pointers
// ---------------------------------------------------------------------------
module store_queue #(
    parameter int SDQ_ENTRIES  = 16,
    parameter int RETIRE_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               alloc_valid,
    output logic                               alloc_ready,
    output logic [$clog2(SDQ_ENTRIES)-1:0]     alloc_idx,
    output logic [$clog2(SDQ_ENTRIES):0]       sdq_marker,
    input  logic                               addr_wr_valid,
    input  logic [$clog2(SDQ_ENTRIES)-1:0]     addr_wr_idx,
    input  logic [31:0]                        addr_wr_addr,
    input  logic [31:0]                        addr_wr_data,
    input  logic [$clog2(RETIRE_WIDTH+1)-1:0]  commit_cnt,
    input  logic                               flush,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [31:0]                        mem_req_addr,
    output logic [31:0]                        mem_req_data,
    output logic [$clog2(SDQ_ENTRIES):0]       count,
    output logic                               empty
);

    localparam int PW = $clog2(SDQ_ENTRIES);
    localparam int CW = $clog2(RETIRE_WIDTH + 1);

    typedef struct packed {
        logic        valid;
        logic        addr_valid;
        logic [31:0] addr;
        logic        committed;
        logic        issued;
    } sdq_entry_t;

    localparam logic [PW:0] PTR_ZERO = {(PW+1){1'b0}};
    localparam logic [PW:0] PTR_ONE  = {{PW{1'b0}}, 1'b1};

    // True when idx lies in the circular window [start, start+len).
    function automatic logic in_window(input logic [PW-1:0] idx,
                                       input logic [PW:0]   start,
                                       input logic [PW:0]   len);
        logic [PW-1:0] off;
        off = idx - start[PW-1:0];
        return ({1'b0, off} < len);
    endfunction

    sdq_entry_t       entry_r [SDQ_ENTRIES];
    logic [31:0]      data_r  [SDQ_ENTRIES];
    logic [PW:0]      head_r;
    logic [PW:0]      cmt_r;
    logic [PW:0]      tail_r;

    logic [PW:0]      occ_s;
    logic             full_s;
    logic [PW:0]      uncmt_s;
    logic [PW:0]      commit_req_s;
    logic [PW:0]      commit_amt_s;
    logic [PW:0]      cmt_nxt_s;
    logic [PW:0]      flush_len_s;
    logic             alloc_fire_s;
    logic             drain_fire_s;
    logic [PW-1:0]    head_idx_s;
    sdq_entry_t       head_entry_s;
    logic [SDQ_ENTRIES-1:0] commit_hit_s;
    logic [SDQ_ENTRIES-1:0] flush_hit_s;

    // Full when indices match but wrap bits differ.
    assign occ_s        = tail_r - head_r;
    assign full_s       = (tail_r[PW-1:0] == head_r[PW-1:0]) && (tail_r[PW] != head_r[PW]);
    assign uncmt_s      = tail_r - cmt_r;
    assign commit_req_s = {{(PW+1-CW){1'b0}}, commit_cnt};
    // Retirement can never run past the allocated stores.
    assign commit_amt_s = (commit_req_s > uncmt_s) ? uncmt_s : commit_req_s;
    assign cmt_nxt_s    = cmt_r + commit_amt_s;
    // Flush squashes what is still uncommitted after this cycle's commit.
    assign flush_len_s  = tail_r - cmt_nxt_s;
    assign alloc_fire_s = alloc_valid & ~full_s & ~flush;
    assign drain_fire_s = mem_req_valid & mem_req_ready;
    assign head_idx_s   = head_r[PW-1:0];
    assign head_entry_s = entry_r[head_idx_s];

    assign alloc_ready  = ~full_s;
    assign alloc_idx    = tail_r[PW-1:0];
    assign sdq_marker   = tail_r;
    assign count        = occ_s;
    assign empty        = (occ_s == PTR_ZERO);

    // The issued bit holds the request up once presented, until the handshake.
    assign mem_req_valid = head_entry_s.valid &
                           ((head_entry_s.addr_valid & head_entry_s.committed) | head_entry_s.issued);
    assign mem_req_addr  = head_entry_s.addr;
    assign mem_req_data  = data_r[head_idx_s];

    // Per-entry masks for the commit window and the flush window.
    always_comb begin
        commit_hit_s = {SDQ_ENTRIES{1'b0}};
        flush_hit_s  = {SDQ_ENTRIES{1'b0}};
        for (int i = 0; i < SDQ_ENTRIES; i++) begin
            commit_hit_s[i] = in_window(PW'(i), cmt_r, commit_amt_s);
            flush_hit_s[i]  = flush & in_window(PW'(i), cmt_nxt_s, flush_len_s);
        end
    end

    // Pointer and entry state update; later assignments take priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r <= PTR_ZERO;
            cmt_r  <= PTR_ZERO;
            tail_r <= PTR_ZERO;
            for (int i = 0; i < SDQ_ENTRIES; i++) begin
                entry_r[i] <= {$bits(sdq_entry_t){1'b0}};
                data_r[i]  <= 32'h0000_0000;
            end
        end else begin
            head_r <= head_r + {{PW{1'b0}}, drain_fire_s};
            cmt_r  <= cmt_nxt_s;
            if (flush) begin
                tail_r <= cmt_nxt_s;
            end else if (alloc_fire_s) begin
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
            for (int i = 0; i < SDQ_ENTRIES; i++) begin
                if (alloc_fire_s && (tail_r[PW-1:0] == PW'(i))) begin
                    entry_r[i].valid      <= 1'b1;
                    entry_r[i].addr_valid <= 1'b0;
                    entry_r[i].committed  <= 1'b0;
                    entry_r[i].issued     <= 1'b0;
                end
                if (addr_wr_valid && (addr_wr_idx == PW'(i)) && entry_r[i].valid) begin
                    entry_r[i].addr       <= addr_wr_addr;
                    entry_r[i].addr_valid <= 1'b1;
                    data_r[i]             <= addr_wr_data;
                end
                if (commit_hit_s[i]) begin
                    entry_r[i].committed <= 1'b1;
                end
                if ((head_idx_s == PW'(i)) && mem_req_valid && !mem_req_ready) begin
                    entry_r[i].issued <= 1'b1;
                end
                if (drain_fire_s && (head_idx_s == PW'(i))) begin
                    entry_r[i].valid      <= 1'b0;
                    entry_r[i].addr_valid <= 1'b0;
                    entry_r[i].committed  <= 1'b0;
                    entry_r[i].issued     <= 1'b0;
                end
                // Squash wins over a same-cycle address write.
                if (flush_hit_s[i]) begin
                    entry_r[i].valid      <= 1'b0;
                    entry_r[i].addr_valid <= 1'b0;
                    entry_r[i].committed  <= 1'b0;
                    entry_r[i].issued     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// ---------------------------------------------------------------------------
// tb_store_queue : directed and randomized bench for store_queue.
// A queue of pending stores (program order, oldest first) is the reference;
// every cycle the DUT's visible outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_store_queue;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_idx;
    logic [4:0]  sdq_marker;
    logic        addr_wr_valid;
    logic [3:0]  addr_wr_idx;
    logic [31:0] addr_wr_addr;
    logic [31:0] addr_wr_data;
    logic [1:0]  commit_cnt;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [4:0]  count;
    logic        empty;

    always #5 clk = ~clk;

    store_queue #(.SDQ_ENTRIES(N), .RETIRE_WIDTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .alloc_idx     (alloc_idx),
        .sdq_marker    (sdq_marker),
        .addr_wr_valid (addr_wr_valid),
        .addr_wr_idx   (addr_wr_idx),
        .addr_wr_addr  (addr_wr_addr),
        .addr_wr_data  (addr_wr_data),
        .commit_cnt    (commit_cnt),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .count         (count),
        .empty         (empty)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          aw;
        bit          cm;
    } st_t;

    st_t q[$];
    int  hp;
    int  drains;
    int  allocs;
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_tail();
        return (hp + q.size()) % (2 * N);
    endfunction

    task automatic check_outputs();
        int sz;
        int tl;
        bit ev;
        sz = q.size();
        tl = model_tail();
        chk("count", 64'(count), 64'(sz));
        chk("empty", 64'(empty), 64'(sz == 0));
        chk("alloc_ready", 64'(alloc_ready), 64'(sz < N));
        chk("alloc_idx", 64'(alloc_idx), 64'(tl % N));
        chk("sdq_marker", 64'(sdq_marker), 64'(tl));
        ev = (sz > 0) && q[0].aw && q[0].cm;
        chk("mem_req_valid", 64'(mem_req_valid), 64'(ev));
        if (ev) begin
            chk("mem_req_addr", 64'(mem_req_addr), 64'(q[0].addr));
            chk("mem_req_data", 64'(mem_req_data), 64'(q[0].data));
        end
    endtask

    task automatic model_step();
        int  sz;
        int  ncm;
        int  c;
        int  keep;
        int  p;
        bit  mv;
        bit  ardy;
        st_t e;
        if (rst) begin
            q.delete();
            hp = 0;
        end else begin
            sz   = q.size();
            ncm  = 0;
            for (int k = 0; k < sz; k++) if (q[k].cm) ncm++;
            mv   = (sz > 0) && q[0].aw && q[0].cm;
            ardy = (sz < N);
            c    = int'(commit_cnt);
            if (c > sz - ncm) c = sz - ncm;
            keep = ncm + c;
            if (addr_wr_valid) begin
                p = (int'(addr_wr_idx) - (hp % N) + N) % N;
                if ((p < sz) && !(flush && (p >= keep))) begin
                    e = q[p];
                    e.addr = addr_wr_addr;
                    e.data = addr_wr_data;
                    e.aw = 1'b1;
                    q[p] = e;
                end
            end
            for (int k = ncm; k < keep; k++) begin
                e = q[k];
                e.cm = 1'b1;
                q[k] = e;
            end
            if (flush) begin
                while (q.size() > keep) e = q.pop_back();
            end
            if (mv && mem_req_ready) begin
                e = q.pop_front();
                hp = (hp + 1) % (2 * N);
                drains++;
            end
            if (alloc_valid && ardy && !flush) begin
                e.addr = 32'h0; e.data = 32'h0; e.aw = 1'b0; e.cm = 1'b0;
                q.push_back(e);
                allocs++;
            end
        end
    endtask

    // One clock: check at negedge, advance model, then clear pulse inputs.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
        rst           = 1'b0;
        alloc_valid   = 1'b0;
        addr_wr_valid = 1'b0;
        commit_cnt    = 2'd0;
        flush         = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_ready"}, 64'(alloc_ready), 64'd1);
        chk({tag, "_idx"}, 64'(alloc_idx), 64'd0);
        chk({tag, "_marker"}, 64'(sdq_marker), 64'd0);
        chk({tag, "_valid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, "_addr"}, 64'(mem_req_addr), 64'd0);
        chk({tag, "_data"}, 64'(mem_req_data), 64'd0);
    endtask

    task automatic write(input int idx, input logic [31:0] a, input logic [31:0] d);
        addr_wr_valid = 1'b1;
        addr_wr_idx   = 4'(idx);
        addr_wr_addr  = a;
        addr_wr_data  = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx_a;
        int cand[$];
        int pick;
        rst = 1'b1; alloc_valid = 1'b0; addr_wr_valid = 1'b0; addr_wr_idx = 4'd0;
        addr_wr_addr = 32'h0; addr_wr_data = 32'h0; commit_cnt = 2'd0;
        flush = 1'b0; mem_req_ready = 1'b0;
        q.delete(); hp = 0; drains = 0; allocs = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("reset");

        // Fill: 16 allocations plus an ignored 17th.
        for (int i = 0; i < 17; i++) begin
            alloc_valid = 1'b1;
            cycle();
        end
        chk("full_count", 64'(count), 64'd16);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        chk("full_marker", 64'(sdq_marker), 64'b10000);
        rst = 1'b1; cycle();

        // Single store: write, then commit, then drain.
        alloc_valid = 1'b1; cycle();
        write(0, 32'h0000_1000, 32'hDEAD_BEEF); cycle();
        commit_cnt = 2'd1; mem_req_ready = 1'b1; cycle();
        chk("one_valid", 64'(mem_req_valid), 64'd1);
        chk("one_addr", 64'(mem_req_addr), 64'h1000);
        chk("one_data", 64'(mem_req_data), 64'hDEAD_BEEF);
        cycle();
        chk("one_empty", 64'(empty), 64'd1);
        mem_req_ready = 1'b0;

        // Flush after partial commit.
        rst = 1'b1; cycle();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1;
            cycle();
        end
        commit_cnt = 2'd2; cycle();
        flush = 1'b1; write(2, 32'h2222_0000, 32'h2222_2222); cycle();
        chk("flush_count", 64'(count), 64'd2);
        chk("flush_marker", 64'(sdq_marker), 64'd2);
        write(3, 32'h3333_0000, 32'h3333_3333); cycle();
        chk("flush_count2", 64'(count), 64'd2);
        mem_req_ready = 1'b1;
        write(0, 32'h0000_A000, 32'h1111_0000); cycle();
        write(1, 32'h0000_A004, 32'h1111_0001); cycle();
        repeat (3) cycle();
        chk("flush_drained", 64'(empty), 64'd1);
        mem_req_ready = 1'b0;

        // Stalled head request, with a flush in the middle of the stall.
        idx_a = model_tail() % N;
        alloc_valid = 1'b1; cycle();
        write(idx_a, 32'hA5A5_0000, 32'h0123_4567); commit_cnt = 2'd1; cycle();
        alloc_valid = 1'b1; cycle();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(mem_req_valid), 64'd1);
            chk("stall_addr", 64'(mem_req_addr), 64'hA5A5_0000);
            chk("stall_data", 64'(mem_req_data), 64'h0123_4567);
            if (i == 2) flush = 1'b1;
            cycle();
        end
        chk("stall_count", 64'(count), 64'd1);
        mem_req_ready = 1'b1; cycle();
        chk("stall_empty", 64'(empty), 64'd1);
        mem_req_ready = 1'b0;

        // Full queue: drain and alloc in the same cycle.
        rst = 1'b1; cycle();
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1;
            cycle();
        end
        write(0, 32'h0000_F000, 32'hF00D_F00D); commit_cnt = 2'd1; cycle();
        chk("fd_valid", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1; alloc_valid = 1'b1; cycle();
        chk("fd_count", 64'(count), 64'd15);
        chk("fd_ready", 64'(alloc_ready), 64'd1);
        chk("fd_idx", 64'(alloc_idx), 64'd0);
        mem_req_ready = 1'b0; alloc_valid = 1'b1; cycle();
        chk("fd_count2", 64'(count), 64'd16);
        chk("fd_marker", 64'(sdq_marker), 64'b10001);

        // Random traffic: 40 stores with random stalls.
        rst = 1'b1; cycle();
        drains = 0; allocs = 0;
        for (int cyc = 0; cyc < 3000 && drains < 40; cyc++) begin
            alloc_valid = (allocs < 40) && ($urandom_range(0, 3) != 0);
            cand.delete();
            for (int k = 0; k < q.size(); k++) if (!q[k].aw) cand.push_back(k);
            if ((cand.size() > 0) && ($urandom_range(0, 1) != 0)) begin
                pick = cand[$urandom_range(0, cand.size() - 1)];
                write((hp + pick) % N, $urandom, $urandom);
            end
            commit_cnt    = 2'($urandom_range(0, 2));
            mem_req_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        mem_req_ready = 1'b0;
        chk("rand_drains", 64'(drains), 64'd40);
        chk("rand_allocs", 64'(allocs), 64'd40);
        chk("rand_marker", 64'(sdq_marker), 64'd8);
        chk("rand_empty", 64'(empty), 64'd1);

        // Reset with live and committed entries discards everything.
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1;
            cycle();
        end
        write(hp % N, 32'h7777_0000, 32'h7777_7777); commit_cnt = 2'd2; cycle();
        chk("pre_rst_valid", 64'(mem_req_valid), 64'd1);
        rst = 1'b1; cycle();
        check_reset_values("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
